// File: rtl/fight_pkg.sv
// Shared types for the fight match sequencer: phase encoding, winner codes and field widths.
// Latency: n/a (types and one pure function only).
// Backpressure: n/a.
package fight_pkg;

  localparam int LIVES_W = 2;
  localparam int TIMER_W = 7;
  localparam int ROUND_W = 4;
  localparam int WINS_W  = 2;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_COUNTDOWN  = 3'd1,
    PH_FIGHT      = 3'd2,
    PH_ROUND_END  = 3'd3,
    PH_MATCH_OVER = 3'd4
  } phase_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Higher score wins, equal is a draw. Lives and wins are both 2 bits wide,
  // so one helper judges both a timed-out round and the final match.
  function automatic winner_t judge(input logic [1:0] p1, input logic [1:0] p2);
    if (p1 > p2) return WIN_P1;
    if (p2 > p1) return WIN_P2;
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/fight_round_ctrl_if.sv
// Game-control bundle between the top-level inputs / player datapath and the match sequencer.
// Latency: wires only.
// Backpressure: none; control=0 is the only stall and it is carried as a plain level.
//   start/control/tick : match start level, run/pause level, game-step strobe
//   lives1/lives2      : player lives from the datapath (0 = KO)
//   step_en/players_rst: one-clk enable and one-clk sync reset to the player registers
//   phase/round_num/timer/wins1/wins2/winner : sequencer status
interface fight_round_ctrl_if;
  import fight_pkg::*;

  logic               start;
  logic               control;
  logic               tick;
  logic [LIVES_W-1:0] lives1;
  logic [LIVES_W-1:0] lives2;

  logic               step_en;
  logic               players_rst;
  logic [2:0]         phase;
  logic [ROUND_W-1:0] round_num;
  logic [TIMER_W-1:0] timer;
  logic [WINS_W-1:0]  wins1;
  logic [WINS_W-1:0]  wins2;
  logic [1:0]         winner;

  modport master (
    output start, control, tick, lives1, lives2,
    input  step_en, players_rst, phase, round_num, timer, wins1, wins2, winner
  );

  modport slave (
    input  start, control, tick, lives1, lives2,
    output step_en, players_rst, phase, round_num, timer, wins1, wins2, winner
  );

endinterface

// File: rtl/fight_tick_counter.sv
// Loadable down-counter that steps on game advance and flags when it sits at 1.
// Latency: load/decrement visible one clk later; is_one is combinational from the count.
// Backpressure: none; dec=0 (pause or no tick) simply holds the count.
//   clk, reset (async active-low), load/load_val (load wins over dec), dec, count, is_one
module fight_tick_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_one
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_one = (count == W'(1));

endmodule

// File: rtl/fight_round_ctrl.sv
// Match sequencer: countdown, timed rounds with KO/timeout detection, round wins, match winner.
// Latency: phase/counters update one clk after the deciding input; step_en and players_rst are combinational.
// Backpressure: control=0 freezes timers, step_en and phase; only a KO can still end a round while paused.
//   clk, reset (async active-low), bus (fight_round_ctrl_if.slave: inputs start/control/tick/lives,
//   outputs step_en/players_rst/phase/round_num/timer/wins1/wins2/winner)
module fight_round_ctrl
  import fight_pkg::*;
#(
  parameter int COUNTDOWN_TICKS = 3,
  parameter int ROUND_TICKS     = 60,
  parameter int HOLD_TICKS      = 2,
  parameter int WINS_TO_MATCH   = 2,
  parameter int MAX_ROUNDS      = 5
) (
  input  logic              clk,
  input  logic              reset,
  fight_round_ctrl_if.slave bus
);

  phase_t             phase_q, phase_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [WINS_W-1:0]  wins1_q, wins1_d;
  logic [WINS_W-1:0]  wins2_q, wins2_d;
  winner_t            winner_q, winner_d;
  logic               start_q;

  logic               adv;
  logic               ko1, ko2;
  logic               start_rise;
  logic               match_done;

  logic               cnt_load, cnt_dec, cnt_one;
  logic [TIMER_W-1:0] cnt_val, cnt;
  logic               tmr_load, tmr_dec, tmr_one;
  logic [TIMER_W-1:0] tmr;

  logic               round_over;
  winner_t            round_res;
  logic               players_rst;

  assign adv        = bus.tick & bus.control;
  assign ko1        = (bus.lives1 == '0);
  assign ko2        = (bus.lives2 == '0);
  // A start held over from MATCH_OVER must not immediately launch a new match.
  assign start_rise = bus.start & ~start_q;
  assign match_done = (wins1_q >= WINS_W'(WINS_TO_MATCH)) ||
                      (wins2_q >= WINS_W'(WINS_TO_MATCH)) ||
                      (round_q == ROUND_W'(MAX_ROUNDS));

  // Shared by COUNTDOWN and ROUND_END; the phases never overlap, so one counter serves both.
  fight_tick_counter #(.W(TIMER_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .is_one   (cnt_one)
  );

  fight_tick_counter #(.W(TIMER_W)) u_round_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (TIMER_W'(ROUND_TICKS)),
    .dec      (tmr_dec),
    .count    (tmr),
    .is_one   (tmr_one)
  );

  assign cnt_dec = adv & ((phase_q == PH_COUNTDOWN) | (phase_q == PH_ROUND_END));
  assign tmr_dec = adv & (phase_q == PH_FIGHT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= PH_IDLE;
      round_q  <= '0;
      wins1_q  <= '0;
      wins2_q  <= '0;
      winner_q <= WIN_NONE;
      start_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      round_q  <= round_d;
      wins1_q  <= wins1_d;
      wins2_q  <= wins2_d;
      winner_q <= winner_d;
      start_q  <= bus.start;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    round_d     = round_q;
    wins1_d     = wins1_q;
    wins2_d     = wins2_q;
    winner_d    = winner_q;
    cnt_load    = 1'b0;
    cnt_val     = TIMER_W'(COUNTDOWN_TICKS);
    tmr_load    = 1'b0;
    players_rst = 1'b0;
    round_over  = 1'b0;
    round_res   = WIN_NONE;

    case (phase_q)
      PH_IDLE: begin
        if (start_rise && bus.control) begin
          phase_d     = PH_COUNTDOWN;
          round_d     = ROUND_W'(1);
          wins1_d     = '0;
          wins2_d     = '0;
          winner_d    = WIN_NONE;
          cnt_load    = 1'b1;
          players_rst = 1'b1;
        end
      end

      PH_COUNTDOWN: begin
        if (adv && cnt_one) begin
          phase_d  = PH_FIGHT;
          tmr_load = 1'b1;
        end
      end

      PH_FIGHT: begin
        // KO is evaluated every clk regardless of pause so a KO on the final step is never lost;
        // it outranks a simultaneous timeout.
        if (ko1 || ko2) begin
          round_over = 1'b1;
          round_res  = (ko1 && ko2) ? WIN_DRAW : (ko2 ? WIN_P1 : WIN_P2);
        end else if (adv && tmr_one) begin
          round_over = 1'b1;
          round_res  = judge(bus.lives1, bus.lives2);
        end
        if (round_over) begin
          phase_d  = PH_ROUND_END;
          winner_d = round_res;
          if (round_res == WIN_P1 && wins1_q != '1) wins1_d = wins1_q + 1'b1;
          if (round_res == WIN_P2 && wins2_q != '1) wins2_d = wins2_q + 1'b1;
          cnt_load = 1'b1;
          cnt_val  = TIMER_W'(HOLD_TICKS);
        end
      end

      PH_ROUND_END: begin
        if (adv && cnt_one) begin
          if (match_done) begin
            phase_d  = PH_MATCH_OVER;
            winner_d = judge(wins1_q, wins2_q);
          end else begin
            phase_d     = PH_COUNTDOWN;
            round_d     = round_q + 1'b1;
            winner_d    = WIN_NONE;
            cnt_load    = 1'b1;
            players_rst = 1'b1;
          end
        end
      end

      PH_MATCH_OVER: begin
        // Leaving clears the scoreboard so round_num reads 0 in IDLE.
        if (bus.start && bus.control) begin
          phase_d  = PH_IDLE;
          round_d  = '0;
          wins1_d  = '0;
          wins2_d  = '0;
          winner_d = WIN_NONE;
        end
      end

      default: phase_d = PH_IDLE;
    endcase
  end

  assign bus.step_en     = (phase_q == PH_FIGHT) & adv & ~ko1 & ~ko2;
  assign bus.players_rst = players_rst;
  assign bus.phase       = phase_q;
  assign bus.round_num   = round_q;
  assign bus.timer       = (phase_q == PH_FIGHT) ? tmr : '0;
  assign bus.wins1       = wins1_q;
  assign bus.wins2       = wins2_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_fight_round_ctrl.sv
module tb_fight_round_ctrl;
  import fight_pkg::*;

  localparam int CD   = 3;
  localparam int RT   = 60;
  localparam int HOLD = 2;
  localparam int WTM  = 2;
  localparam int MAXR = 5;

  logic clk = 1'b0;
  logic reset;

  fight_round_ctrl_if bus();

  fight_round_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: match described as plain integers
  // (phase number, round, wins, winner code, remaining countdown/hold ticks, remaining fight ticks).
  int m_ph, m_round, m_w1, m_w2, m_win, m_left, m_fight_left;
  bit m_prev_start;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int better(input int a, input int b);
    if (a > b) return 1;
    if (b > a) return 2;
    return 3;
  endfunction

  task automatic model_clear();
    m_ph = 0; m_round = 0; m_w1 = 0; m_w2 = 0; m_win = 0;
    m_left = 0; m_fight_left = 0; m_prev_start = 1'b0;
  endtask

  // One clock: apply inputs after the edge, compare everything, then advance the model.
  task automatic cyc(input bit s, input bit c, input bit t, input int l1, input int l2);
    bit adv;
    int e_step, e_prst, result;
    int n_ph, n_round, n_w1, n_w2, n_win, n_left, n_fight;
    @(posedge clk);
    #1;
    bus.start = s; bus.control = c; bus.tick = t;
    bus.lives1 = 2'(l1); bus.lives2 = 2'(l2);
    #1;
    adv = t && c;
    n_ph = m_ph; n_round = m_round; n_w1 = m_w1; n_w2 = m_w2; n_win = m_win;
    n_left = m_left; n_fight = m_fight_left;
    e_prst = 0;
    e_step = (m_ph == 2 && adv && l1 != 0 && l2 != 0) ? 1 : 0;
    result = 0;
    if (m_ph == 0) begin
      if (s && !m_prev_start && c) begin
        n_ph = 1; n_round = 1; n_w1 = 0; n_w2 = 0; n_win = 0; n_left = CD; e_prst = 1;
      end
    end else if (m_ph == 1) begin
      if (adv) begin
        if (m_left == 1) begin n_ph = 2; n_fight = RT; end
        else n_left = m_left - 1;
      end
    end else if (m_ph == 2) begin
      if (l1 == 0 && l2 == 0) result = 3;
      else if (l2 == 0) result = 1;
      else if (l1 == 0) result = 2;
      else if (adv) begin
        if (m_fight_left == 1) result = better(l1, l2);
        else n_fight = m_fight_left - 1;
      end
      if (result != 0) begin
        n_ph = 3; n_win = result; n_left = HOLD;
        if (result == 1 && m_w1 < 3) n_w1 = m_w1 + 1;
        if (result == 2 && m_w2 < 3) n_w2 = m_w2 + 1;
      end
    end else if (m_ph == 3) begin
      if (adv) begin
        if (m_left == 1) begin
          if (m_w1 >= WTM || m_w2 >= WTM || m_round == MAXR) begin
            n_ph = 4; n_win = better(m_w1, m_w2);
          end else begin
            n_ph = 1; n_round = m_round + 1; n_win = 0; n_left = CD; e_prst = 1;
          end
        end else n_left = m_left - 1;
      end
    end else begin
      if (s && c) begin
        n_ph = 0; n_round = 0; n_w1 = 0; n_w2 = 0; n_win = 0;
      end
    end

    check_eq("phase", bus.phase, m_ph);
    check_eq("round_num", bus.round_num, m_round);
    check_eq("wins1", bus.wins1, m_w1);
    check_eq("wins2", bus.wins2, m_w2);
    check_eq("winner", bus.winner, m_win);
    check_eq("timer", bus.timer, (m_ph == 2) ? m_fight_left : 0);
    check_eq("step_en", bus.step_en, e_step);
    check_eq("players_rst", bus.players_rst, e_prst);

    m_ph = n_ph; m_round = n_round; m_w1 = n_w1; m_w2 = n_w2; m_win = n_win;
    m_left = n_left; m_fight_left = n_fight; m_prev_start = s;
  endtask

  task automatic ticks(input int n, input int l1, input int l2);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, l1, l2);
  endtask

  // From MATCH_OVER (or IDLE) into COUNTDOWN of a fresh match.
  task automatic new_match();
    if (m_ph == 4) cyc(1'b1, 1'b1, 1'b0, 3, 3);
    cyc(1'b0, 1'b1, 1'b0, 3, 3);
    cyc(1'b1, 1'b1, 1'b0, 3, 3);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    bus.tick = 1'b1; bus.control = 1'b1; bus.lives1 = 2'd3; bus.lives2 = 2'd3;
    #2;
    reset = 1'b0;
    #1;
    check_eq({tag, "_phase"}, bus.phase, 0);
    check_eq({tag, "_round"}, bus.round_num, 0);
    check_eq({tag, "_wins1"}, bus.wins1, 0);
    check_eq({tag, "_wins2"}, bus.wins2, 0);
    check_eq({tag, "_step_en"}, bus.step_en, 0);
    check_eq({tag, "_players_rst"}, bus.players_rst, 0);
    check_eq({tag, "_timer"}, bus.timer, 0);
    bus.start = 1'b0; bus.control = 1'b0; bus.tick = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.control = 1'b0; bus.tick = 1'b0;
    bus.lives1 = 2'd3; bus.lives2 = 2'd3;
    model_clear();
    #23;
    check_eq("rst_phase", bus.phase, 0);
    check_eq("rst_winner", bus.winner, 0);
    @(negedge clk);
    reset = 1'b1;

    // Start, countdown of three ticks, fight opens with a full timer.
    cyc(1'b1, 1'b1, 1'b0, 3, 3);
    ticks(CD, 3, 3);
    cyc(1'b0, 1'b1, 1'b0, 3, 3);
    check_eq("t2_phase", bus.phase, 2);
    check_eq("t2_timer", bus.timer, RT);

    // P2 knocked out: round to P1 on the next clk.
    ticks(4, 3, 3);
    cyc(1'b0, 1'b1, 1'b0, 3, 0);
    cyc(1'b0, 1'b1, 1'b0, 3, 3);
    check_eq("t3_phase", bus.phase, 3);
    check_eq("t3_winner", bus.winner, 1);
    check_eq("t3_wins1", bus.wins1, 1);
    check_eq("t3_step_en", bus.step_en, 0);
    ticks(HOLD, 3, 3);

    // Double KO: draw, nobody scores.
    ticks(CD, 3, 3);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 3, 3);
    check_eq("t4_winner", bus.winner, 3);
    check_eq("t4_wins1", bus.wins1, 1);
    check_eq("t4_wins2", bus.wins2, 0);
    ticks(HOLD, 3, 3);

    // Pause holds the timer, then a full timeout goes to the player with more lives.
    ticks(CD, 3, 2);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 3, 2);
    check_eq("t5_frozen_timer", bus.timer, RT);
    ticks(RT, 3, 2);
    cyc(1'b0, 1'b1, 1'b0, 3, 3);
    check_eq("t5_phase", bus.phase, 3);
    check_eq("t5_winner", bus.winner, 1);
    ticks(HOLD, 3, 3);
    cyc(1'b0, 1'b1, 1'b0, 3, 3);
    check_eq("t5_match_phase", bus.phase, 4);

    // Start held through MATCH_OVER -> IDLE must not relaunch a match.
    cyc(1'b1, 1'b1, 1'b0, 3, 3);
    cyc(1'b1, 1'b1, 1'b0, 3, 3);
    cyc(1'b1, 1'b1, 1'b0, 3, 3);
    check_eq("held_start_idle", bus.phase, 0);

    // P2 takes two rounds by KO.
    new_match();
    for (int r = 0; r < 2; r++) begin
      ticks(CD, 3, 3);
      cyc(1'b0, 1'b1, 1'b0, 0, 3);
      ticks(HOLD, 3, 3);
    end
    cyc(1'b0, 1'b1, 1'b0, 3, 3);
    check_eq("t6_p2_phase", bus.phase, 4);
    check_eq("t6_p2_winner", bus.winner, 2);

    // Five draws hit the round cap.
    new_match();
    for (int r = 0; r < MAXR; r++) begin
      ticks(CD, 3, 3);
      cyc(1'b0, 1'b1, 1'b0, 0, 0);
      ticks(HOLD, 3, 3);
    end
    cyc(1'b0, 1'b1, 1'b0, 3, 3);
    check_eq("t6_draw_phase", bus.phase, 4);
    check_eq("t6_draw_winner", bus.winner, 3);
    check_eq("t6_draw_round", bus.round_num, MAXR);

    // Reset in the middle of a fight.
    new_match();
    ticks(CD, 3, 3);
    cyc(1'b0, 1'b1, 1'b0, 3, 3);
    async_reset("t1");

    // Randomised play at two KO rates, with the odd reset.
    for (int blk = 0; blk < 4; blk++) begin
      int ko_rng;
      ko_rng = (blk % 2 == 0) ? 40 : 800;
      for (int i = 0; i < 1500; i++) begin
        bit s, c, t;
        int l1, l2;
        if ($urandom_range(0, 1999) == 0) async_reset("rnd_rst");
        s  = ($urandom_range(0, 24) == 0);
        c  = ($urandom_range(0, 7) != 0);
        t  = ($urandom_range(0, 1) == 1);
        l1 = ($urandom_range(0, ko_rng) == 0) ? 0 : int'($urandom_range(1, 3));
        l2 = ($urandom_range(0, ko_rng) == 0) ? 0 : int'($urandom_range(1, 3));
        cyc(s, c, t, l1, l2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
